// File: rtl/controlador_deslocamento_if.sv
// Handshake and data bus of the shift controller.
// The requester uses the master side; the controller uses the slave side.
interface controlador_deslocamento_if #(
   parameter int unsigned LARG  = 8,
   parameter int unsigned QBITS = 3
);
   logic             inicio;
   logic [LARG-1:0]  operando;
   logic [1:0]       modo;
   logic [QBITS-1:0] quant;
   logic             pronto;
   logic             valido;
   logic [LARG-1:0]  resultado;
   logic [LARG-1:0]  resto;
   logic             estouro;

   modport master (
      output inicio, operando, modo, quant,
      input  pronto, valido, resultado, resto, estouro
   );

   modport slave (
      input  inicio, operando, modo, quant,
      output pronto, valido, resultado, resto, estouro
   );
endinterface

// File: rtl/controlador_deslocamento.sv
// Sequential shifter: shifts one bit per cycle (left, logical right,
// arithmetic right or rotate left) and flags the result with a one-cycle
// valido pulse. Collects the bits lost in divide modes and a left-shift
// overflow flag.
module controlador_deslocamento #(
   parameter int unsigned LARG  = 8,
   parameter int unsigned QBITS = 3
) (
   input logic                    clk,
   input logic                    rst_n,
   controlador_deslocamento_if.slave bus
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DESLOCA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   estado_t          estado;
   estado_t          prox;
   logic             aceita;
   logic             pronto_c;
   logic             valido_c;

   logic [LARG-1:0]  acc;
   logic [LARG-1:0]  resto_r;
   logic [LARG-1:0]  mascara;
   logic [1:0]       modo_r;
   logic [QBITS-1:0] cont;
   logic             estouro_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      prox     = estado;
      pronto_c = 1'b0;
      valido_c = 1'b0;
      aceita   = 1'b0;
      case (estado)
         OCIOSO: begin
            pronto_c = 1'b1;
            if (bus.inicio) begin
               aceita = 1'b1;
               prox   = (bus.quant == '0) ? FIM : DESLOCA;
            end
         end
         DESLOCA: begin
            if (cont == QBITS'(1)) begin
               prox = FIM;
            end
         end
         FIM: begin
            valido_c = 1'b1;
            prox     = OCIOSO;
         end
         default: begin
            prox = OCIOSO;
         end
      endcase
   end

   // Operand latch and one-bit-per-cycle shift datapath.
   // mascara walks upward from bit 0 so each bit dropped off the right end
   // lands right-aligned in resto in the order it was shifted out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         resto_r   <= '0;
         mascara   <= '0;
         modo_r    <= '0;
         cont      <= '0;
         estouro_r <= 1'b0;
      end else if (aceita) begin
         acc       <= bus.operando;
         modo_r    <= bus.modo;
         cont      <= bus.quant;
         resto_r   <= '0;
         mascara   <= LARG'(1);
         estouro_r <= 1'b0;
      end else if (estado == DESLOCA) begin
         cont    <= cont - QBITS'(1);
         mascara <= mascara << 1;
         case (modo_r)
            2'b00: begin
               acc       <= {acc[LARG-2:0], 1'b0};
               estouro_r <= estouro_r | acc[LARG-1];
            end
            2'b01: begin
               acc <= {1'b0, acc[LARG-1:1]};
               if (acc[0]) begin
                  resto_r <= resto_r | mascara;
               end
            end
            2'b10: begin
               acc <= {acc[LARG-1], acc[LARG-1:1]};
               if (acc[0]) begin
                  resto_r <= resto_r | mascara;
               end
            end
            default: begin
               acc <= {acc[LARG-2:0], acc[LARG-1]};
            end
         endcase
      end
   end

   assign bus.pronto    = pronto_c;
   assign bus.valido    = valido_c;
   assign bus.resultado = acc;
   assign bus.resto     = resto_r;
   assign bus.estouro   = estouro_r;

endmodule

// File: tb/tb_controlador_deslocamento.sv
// Self-checking bench for controlador_deslocamento (LARG=8, QBITS=3).
module tb_controlador_deslocamento;

   localparam int unsigned LARG  = 8;
   localparam int unsigned QBITS = 3;

   logic clk;
   logic rst_n;

   controlador_deslocamento_if #(.LARG(LARG), .QBITS(QBITS)) bus ();

   controlador_deslocamento #(.LARG(LARG), .QBITS(QBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] op;
      logic [1:0] modo;
      logic [2:0] q;
      logic [7:0] res;
      logic [7:0] resto;
      logic       est;
   } vetor_t;

   vetor_t tab [11];

   task automatic chk(input string nome, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", nome, got, exp, $time);
      end
   endtask

   // Reference model computed directly from the arithmetic definitions
   task automatic modelo(input int unsigned op, input int unsigned m, input int unsigned q,
                         output int unsigned res, output int unsigned rst, output int unsigned est);
      int s;
      res = 0; rst = 0; est = 0;
      case (m)
         0: begin
            res = (op << q) & 32'hFF;
            est = (((op << q) >> 8) != 0) ? 1 : 0;
         end
         1: begin
            res = op >> q;
            rst = op & ((1 << q) - 1);
         end
         2: begin
            s   = (op >= 128) ? int'(op) - 256 : int'(op);
            res = (s >>> q) & 32'hFF;
            rst = op & ((1 << q) - 1);
         end
         default: begin
            res = ((op << q) | (op >> (8 - q))) & 32'hFF;
         end
      endcase
   endtask

   // One full transaction: accept, latency count, result and pulse width
   task automatic executa(input string nome, input logic [7:0] op, input logic [1:0] m,
                          input logic [2:0] q, input logic [7:0] e_res,
                          input logic [7:0] e_resto, input logic e_est);
      int n;
      @(negedge clk);
      chk({nome, ".pronto_idle"}, bus.pronto, 1);
      bus.inicio   = 1'b1;
      bus.operando = op;
      bus.modo     = m;
      bus.quant    = q;
      @(posedge clk);
      #1;
      bus.inicio = 1'b0;
      chk({nome, ".pronto_busy"}, bus.pronto, 0);
      n = 0;
      while (!bus.valido && n < 40) begin
         bus.operando = 8'($urandom);
         bus.modo     = 2'($urandom);
         bus.quant    = 3'($urandom);
         bus.inicio   = 1'($urandom);
         @(posedge clk);
         #1;
         bus.inicio = 1'b0;
         n++;
      end
      chk({nome, ".latency"}, n, q);
      chk({nome, ".resultado"}, bus.resultado, e_res);
      chk({nome, ".resto"}, bus.resto, e_resto);
      chk({nome, ".estouro"}, bus.estouro, e_est);
      @(posedge clk);
      #1;
      chk({nome, ".valido_1cycle"}, bus.valido, 0);
      chk({nome, ".pronto_back"}, bus.pronto, 1);
      chk({nome, ".resultado_hold"}, bus.resultado, e_res);
   endtask

   initial begin
      int unsigned r_res, r_rst, r_est;
      int pulsos, lat;
      logic [7:0] res_pulso;
      logic       est_pulso;
      logic       viu_valido;
      logic [7:0] op;
      logic [1:0] m;
      logic [2:0] q;

      tab[0]  = '{8'h75, 2'd0, 3'd2, 8'hD4, 8'h00, 1'b1};
      tab[1]  = '{8'h75, 2'd1, 3'd3, 8'h0E, 8'h05, 1'b0};
      tab[2]  = '{8'h88, 2'd2, 3'd2, 8'hE2, 8'h00, 1'b0};
      tab[3]  = '{8'h75, 2'd3, 3'd4, 8'h57, 8'h00, 1'b0};
      tab[4]  = '{8'hA5, 2'd0, 3'd0, 8'hA5, 8'h00, 1'b0};
      tab[5]  = '{8'h80, 2'd2, 3'd7, 8'hFF, 8'h00, 1'b0};
      tab[6]  = '{8'hFF, 2'd1, 3'd7, 8'h01, 8'h7F, 1'b0};
      tab[7]  = '{8'h01, 2'd0, 3'd7, 8'h80, 8'h00, 1'b0};
      tab[8]  = '{8'h81, 2'd3, 3'd1, 8'h03, 8'h00, 1'b0};
      tab[9]  = '{8'hFF, 2'd2, 3'd0, 8'hFF, 8'h00, 1'b0};
      tab[10] = '{8'h80, 2'd0, 3'd1, 8'h00, 8'h00, 1'b1};

      rst_n        = 1'b0;
      bus.inicio   = 1'b0;
      bus.operando = '0;
      bus.modo     = '0;
      bus.quant    = '0;
      #1;
      chk("reset.pronto", bus.pronto, 1);
      chk("reset.valido", bus.valido, 0);
      chk("reset.resultado", bus.resultado, 0);
      chk("reset.resto", bus.resto, 0);
      chk("reset.estouro", bus.estouro, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         executa($sformatf("vec%0d", i), tab[i].op, tab[i].modo, tab[i].q,
                 tab[i].res, tab[i].resto, tab[i].est);
      end

      // Request during DESLOCA must be ignored
      @(negedge clk);
      bus.inicio = 1'b1; bus.operando = 8'h75; bus.modo = 2'd0; bus.quant = 3'd7;
      @(posedge clk);
      #1;
      bus.inicio = 1'b0;
      @(negedge clk);
      bus.inicio = 1'b1; bus.operando = 8'hFF; bus.modo = 2'd1; bus.quant = 3'd1;
      @(posedge clk);
      #1;
      bus.inicio = 1'b0;
      pulsos = 0; lat = -1; res_pulso = '0; est_pulso = 1'b0;
      for (int e = 2; e <= 14; e++) begin
         @(posedge clk);
         #1;
         if (bus.valido) begin
            pulsos++;
            if (lat < 0) begin
               lat = e; res_pulso = bus.resultado; est_pulso = bus.estouro;
            end
         end
      end
      chk("ignore.pulses", pulsos, 1);
      chk("ignore.latency", lat, 7);
      chk("ignore.resultado", res_pulso, 8'h80);
      chk("ignore.estouro", est_pulso, 1);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      bus.inicio = 1'b1; bus.operando = 8'h75; bus.modo = 2'd1; bus.quant = 3'd7;
      @(posedge clk);
      #1;
      bus.inicio = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort.pronto", bus.pronto, 1);
      chk("abort.valido", bus.valido, 0);
      chk("abort.resultado", bus.resultado, 0);
      chk("abort.resto", bus.resto, 0);
      chk("abort.estouro", bus.estouro, 0);
      viu_valido = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.valido) viu_valido = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.valido) viu_valido = 1'b1;
      end
      chk("abort.no_valido", viu_valido, 0);
      executa("after_reset", 8'h75, 2'd1, 3'd3, 8'h0E, 8'h05, 1'b0);

      // Randomized transactions against the reference model
      for (int k = 0; k < 60; k++) begin
         op = 8'($urandom);
         m  = 2'($urandom_range(0, 3));
         q  = 3'($urandom_range(0, 7));
         modelo(op, m, q, r_res, r_rst, r_est);
         executa($sformatf("rnd%0d", k), op, m, q, 8'(r_res), 8'(r_rst), 1'(r_est));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controlador_deslocamento.md
CONTROLADOR_DESLOCAMENTO -- requirements
Module: controlador_deslocamento

Interface
REQ-001 Parameter: LARG, default 8, operand and result width in bits.
REQ-002 Parameter: QBITS, default 3, width of the shift-amount field; the maximum shift is 2^QBITS-1.
REQ-003 Port: clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: inicio, input, 1, start request; sampled on the rising edge.
REQ-006 Port: operando, input, LARG, value to be scaled; sampled on the accepting edge only.
REQ-007 Port: modo, input, 2, operation: 00 = multiply by 2^quant (logical left), 01 = divide by 2^quant (logical right), 10 = signed divide (arithmetic right, sign fill), 11 = rotate left.
REQ-008 Port: quant, input, QBITS, shift amount; sampled on the accepting edge only.
REQ-009 Port: pronto, output, 1, high while idle and able to accept inicio.
REQ-010 Port: valido, output, 1, one-cycle pulse marking the result as final.
REQ-011 Port: resultado, output, LARG, scaled value.
REQ-012 Port: resto, output, LARG, bits shifted out in divide modes (01/10), right-aligned; 0 in other modes.
REQ-013 Port: estouro, output, 1, mode 00 only: high if any 1 bit was shifted out of the MSB; 0 in other modes.

Function
REQ-014 The FSM SHALL have three states: OCIOSO, DESLOCA and FIM.
REQ-015 pronto SHALL be 1 exactly when the FSM is in OCIOSO.
REQ-016 Accept: inicio=1 in OCIOSO on a rising edge; on that edge operando, modo and quant SHALL be latched, resto and estouro SHALL be cleared, and the counter SHALL be loaded with quant.
REQ-017 On accept with quant=0 the FSM SHALL go directly to FIM; otherwise it SHALL go to DESLOCA.
REQ-018 In DESLOCA, each edge SHALL shift the accumulator by exactly one bit per modo and decrement the counter; when the counter reaches 0, the FSM SHALL go to FIM.
REQ-019 While the FSM is in FIM, valido SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to OCIOSO unconditionally.
REQ-020 Latency SHALL be quant+1 cycles: valido rises quant edges after the accepting edge, and one accept SHALL produce one valido pulse.
REQ-021 inicio SHALL be ignored in DESLOCA and FIM, with no effect on the running operation or its latched inputs.
REQ-022 Inputs operando, modo and quant SHALL be don't-care outside the accepting edge.
REQ-023 resultado, resto and estouro SHALL be final and stable while valido=1 and SHALL hold until the next accept.
REQ-024 resultado SHALL equal operando<<quant (LARG LSBs kept) in mode 00.
REQ-025 resultado SHALL equal operando>>quant, zero fill, in mode 01.
REQ-026 resultado SHALL equal operando>>>quant, MSB fill, in mode 10.
REQ-027 resultado SHALL be operando rotated left by quant in mode 11.
REQ-028 In modes 01/10, resto SHALL equal operando AND (2^quant-1).
REQ-029 With quant=0, resultado SHALL equal operando, resto SHALL be 0 and estouro SHALL be 0.
REQ-030 Intermediate values of resultado during DESLOCA SHALL be unspecified; consumers SHALL use only values qualified by valido.

Reset
REQ-031 rst_n=0 SHALL force OCIOSO immediately, independent of clk, with pronto=1, valido=0, resultado=0, resto=0, estouro=0 and counter=0.
REQ-032 Reset asserted during DESLOCA or FIM SHALL abort the operation with no valido pulse; the first accept after release SHALL behave as from power-up.

Verification
REQ-033 Scenario 1: operando=0x75, modo=00, quant=2 -> valido 2 edges after accept, resultado=0xD4, estouro=1, resto=0.
REQ-034 Scenario 2: operando=0x75, modo=01, quant=3 -> resultado=0x0E, resto=0x05, estouro=0, valido 3 edges after accept.
REQ-035 Scenario 3: operando=0x88, modo=10, quant=2 -> resultado=0xE2, resto=0x00.
REQ-036 Scenario 4: operando=0x75, modo=11, quant=4 -> resultado=0x57; then operando=0xA5, modo=00, quant=0 -> valido on the edge after accept, resultado=0xA5, estouro=0.
REQ-037 Scenario 5: accept 0x75/00/7, then pulse inicio with 0xFF/01/1 during DESLOCA -> second request ignored; a single valido with resultado=0x80 and estouro=1.
REQ-038 Scenario 6: accept 0x75/01/7, drop rst_n at cycle 3 -> all outputs at reset values immediately and no valido; after release, 0x75/01/3 -> resultado=0x0E, resto=0x05.
